uart_crc_frame_rx: RTL and testbench

UART_CRC_FRAME_RX -- requirements
Module: uart_crc_frame_rx

---
 rtl/uart_crc_pkg.sv | 28 ++
 rtl/uart_rx_sampler.sv | 53 +++++
 rtl/uart_crc_frame_rx.sv | 139 +++++++++++++
 tb/tb_uart_crc_frame_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_crc_pkg.sv
// Shared definitions for the UART CRC-8 framed link: CRC constants,
// receiver state encoding and the byte-wide CRC-8 helper that the
// transmit-side generator also uses.
package uart_crc_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } rx_state_t;

  // CRC-8 over one byte, MSB first, no reflection, no final XOR
  function automatic logic [7:0] crc8(input logic [7:0] data);
    logic [7:0] crc;
    crc = CRC8_INIT ^ data;
    for (int i = 0; i < 8; i++) begin
      if (crc[7]) crc = {crc[6:0], 1'b0} ^ CRC8_POLY;
      else        crc = {crc[6:0], 1'b0};
    end
    return crc;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end for the receiver: two-flop synchronizer, falling-edge
// detector and the baud counter that produces mid-bit sample strobes.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_in,
  input  logic clear,
  input  logic half_period,
  output logic fall,
  output logic sample_strobe,
  output logic sample_bit
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic sync1;
  logic sync2;
  logic prev;
  logic [CW-1:0] cnt;

  // Bring the asynchronous line into the clock domain; all stages idle high
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall          = prev & ~sync2;
  assign sample_bit    = sync2;
  assign sample_strobe = (cnt == (half_period ? HALF_LAST : FULL_LAST));

  // Baud counter restarts on every strobe so strobes land one bit apart
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || sample_strobe) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_crc_frame_rx.sv
// Two-byte UART frame receiver: a data byte followed by its CRC-8 byte.
// Reports the accepted frame with a CRC check, or flags framing and
// inter-byte timeout errors.
module uart_crc_frame_rx
  import uart_crc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic [7:0] rx_crc,
  output logic       rx_valid,
  output logic       crc_ok,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       rx_busy
);

  localparam int GW = $clog2(TIMEOUT_BITS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_BITS - 1);

  rx_state_t     state;
  logic          byte_idx;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    data_hold;
  logic [GW-1:0] gap_cnt;

  logic fall;
  logic sample_strobe;
  logic sample_bit;
  logic clear_cnt;
  logic half_period;
  logic [7:0] crc_expect;

  // The baud counter sits at zero while idle and restarts when the CRC
  // byte's start edge arrives during the inter-byte gap
  assign clear_cnt   = (state == ST_IDLE) || ((state == ST_GAP) && fall);
  assign half_period = (state == ST_START);
  assign rx_busy     = (state != ST_IDLE);
  assign crc_expect  = crc8(data_hold);

  uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .clear        (clear_cnt),
    .half_period  (half_period),
    .fall         (fall),
    .sample_strobe(sample_strobe),
    .sample_bit   (sample_bit)
  );

  // Frame FSM with registered result and error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      byte_idx    <= 1'b0;
      bit_cnt     <= '0;
      shift       <= '0;
      data_hold   <= '0;
      gap_cnt     <= '0;
      rx_data     <= '0;
      rx_crc      <= '0;
      rx_valid    <= 1'b0;
      crc_ok      <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fall) state <= ST_START;
        end
        ST_START: begin
          if (sample_strobe) begin
            if (!sample_bit) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              state    <= ST_IDLE;
              byte_idx <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (sample_strobe) begin
            shift <= {sample_bit, shift[7:1]};
            if (bit_cnt == 3'd7) state <= ST_STOP;
            else                 bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (sample_strobe) begin
            if (!sample_bit) begin
              frame_err <= 1'b1;
              byte_idx  <= 1'b0;
              state     <= fall ? ST_START : ST_IDLE;
            end else if (!byte_idx) begin
              data_hold <= shift;
              gap_cnt   <= '0;
              state     <= ST_GAP;
            end else begin
              rx_data  <= data_hold;
              rx_crc   <= shift;
              crc_ok   <= (crc_expect == shift);
              rx_valid <= 1'b1;
              byte_idx <= 1'b0;
              state    <= fall ? ST_START : ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (fall) begin
            byte_idx <= 1'b1;
            state    <= ST_START;
          end else if (sample_strobe) begin
            if (gap_cnt == GAP_LAST) begin
              timeout_err <= 1'b1;
              byte_idx    <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_crc_frame_rx.sv
// Directed bench for uart_crc_frame_rx: drives serial frames bit by bit
// and checks results against hand-computed values.
module tb_uart_crc_frame_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_data;
  logic [7:0] rx_crc;
  logic       rx_valid;
  logic       crc_ok;
  logic       frame_err;
  logic       timeout_err;
  logic       rx_busy;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int tout_cnt  = 0;
  int valid_cyc = 0;
  int tout_cyc  = 0;
  int start_cyc;
  int v0, f0, t0;

  uart_crc_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_crc     (rx_crc),
    .rx_valid   (rx_valid),
    .crc_ok     (crc_ok),
    .frame_err  (frame_err),
    .timeout_err(timeout_err),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so pulse timing can be measured
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse, sampled away from the active edge
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (timeout_err) begin
      tout_cnt <= tout_cnt + 1;
      tout_cyc <= cyc;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one UART byte: start, 8 data bits LSB first, stop; start_cyc
  // marks the cycle the start bit went onto the line
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    start_cyc = cyc;
    rx_in = 1'b0;
    idle(CPB - 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_in = b[i];
      idle(CPB - 1);
    end
    @(negedge clk);
    rx_in = stop_bit;
    idle(CPB - 1);
    @(negedge clk);
    rx_in = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int fr0;
    reset = 1'b1;
    rx_in = 1'b1;
    idle(4);
    reset = 1'b0;
    idle(2);
    checkOutput("reset rx_data", rx_data, 0);
    checkOutput("reset rx_crc", rx_crc, 0);
    checkOutput("reset rx_valid", rx_valid, 0);
    checkOutput("reset crc_ok", crc_ok, 0);
    checkOutput("reset frame_err", frame_err, 0);
    checkOutput("reset timeout_err", timeout_err, 0);
    checkOutput("reset rx_busy", rx_busy, 0);

    $display("[TB] frame 0x01 / 0x07");
    v0 = valid_cnt; f0 = ferr_cnt;
    applyStimulus(8'h01, 1'b1);
    idle(2 * CPB);
    applyStimulus(8'h07, 1'b1);
    fr0 = start_cyc;
    idle(40);
    checkOutput("good valid count", valid_cnt - v0, 1);
    checkOutput("good valid latency", valid_cyc - fr0, 155);
    checkOutput("good rx_data", rx_data, 8'h01);
    checkOutput("good rx_crc", rx_crc, 8'h07);
    checkOutput("good crc_ok", crc_ok, 1);
    checkOutput("good frame_err count", ferr_cnt - f0, 0);

    $display("[TB] frame 0x80 / 0x88");
    v0 = valid_cnt;
    applyStimulus(8'h80, 1'b1);
    idle(CPB);
    applyStimulus(8'h88, 1'b1);
    idle(40);
    checkOutput("bad crc valid count", valid_cnt - v0, 1);
    checkOutput("bad crc rx_data", rx_data, 8'h80);
    checkOutput("bad crc rx_crc", rx_crc, 8'h88);
    checkOutput("bad crc crc_ok", crc_ok, 0);

    $display("[TB] 0x55 with low stop bit");
    v0 = valid_cnt; f0 = ferr_cnt;
    applyStimulus(8'h55, 1'b0);
    idle(40);
    checkOutput("stop low frame_err count", ferr_cnt - f0, 1);
    checkOutput("stop low valid count", valid_cnt - v0, 0);
    checkOutput("stop low rx_data held", rx_data, 8'h80);
    checkOutput("stop low rx_crc held", rx_crc, 8'h88);
    checkOutput("stop low rx_busy", rx_busy, 0);

    $display("[TB] 0xA5 then idle line");
    v0 = valid_cnt; t0 = tout_cnt; f0 = ferr_cnt;
    applyStimulus(8'hA5, 1'b1);
    fr0 = start_cyc;
    idle(21 * CPB + 20);
    checkOutput("timeout count", tout_cnt - t0, 1);
    checkOutput("timeout latency", tout_cyc - fr0, 475);
    checkOutput("timeout valid count", valid_cnt - v0, 0);
    checkOutput("timeout frame_err count", ferr_cnt - f0, 0);
    checkOutput("timeout rx_busy", rx_busy, 0);
    checkOutput("timeout rx_data held", rx_data, 8'h80);

    $display("[TB] 3-cycle glitch");
    v0 = valid_cnt; t0 = tout_cnt; f0 = ferr_cnt;
    @(negedge clk);
    rx_in = 1'b0;
    idle(3);
    rx_in = 1'b1;
    idle(9);
    checkOutput("glitch rx_busy", rx_busy, 0);
    checkOutput("glitch events", (valid_cnt - v0) + (ferr_cnt - f0) + (tout_cnt - t0), 0);
    checkOutput("glitch rx_data held", rx_data, 8'h80);

    $display("[TB] reset during CRC byte bit 4");
    v0 = valid_cnt; t0 = tout_cnt; f0 = ferr_cnt;
    applyStimulus(8'h3C, 1'b1);
    idle(CPB);
    @(negedge clk);
    rx_in = 1'b0;
    idle(CPB - 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_in = 1'b1;
      idle(CPB - 1);
    end
    @(negedge clk);
    rx_in = 1'b0;
    idle(8);
    reset = 1'b1;
    rx_in = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(40);
    checkOutput("mid reset rx_data", rx_data, 0);
    checkOutput("mid reset rx_crc", rx_crc, 0);
    checkOutput("mid reset crc_ok", crc_ok, 0);
    checkOutput("mid reset rx_busy", rx_busy, 0);
    checkOutput("mid reset events", (valid_cnt - v0) + (ferr_cnt - f0) + (tout_cnt - t0), 0);
    applyStimulus(8'h00, 1'b1);
    idle(CPB);
    applyStimulus(8'h00, 1'b1);
    idle(40);
    checkOutput("post reset valid count", valid_cnt - v0, 1);
    checkOutput("post reset crc_ok", crc_ok, 1);
    checkOutput("post reset rx_data", rx_data, 0);

    $display("[TB] line stuck low after reset");
    v0 = valid_cnt; f0 = ferr_cnt;
    @(negedge clk);
    reset = 1'b1;
    rx_in = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(400);
    checkOutput("stuck low frame_err count", ferr_cnt - f0, 1);
    checkOutput("stuck low valid count", valid_cnt - v0, 0);
    checkOutput("stuck low rx_busy", rx_busy, 0);
    rx_in = 1'b1;
    idle(20);
    checkOutput("stuck low released busy", rx_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
